// File: rtl/noc_rr_arbiter_node.sv
`default_nettype none
// ==========================================================================
// Module   : noc_rr_arbiter_node
// Brief    : Round-robin request arbiter node with tag-routed reply demux.
//            Optional grant/stall counters under NOC_ARB_STATS_EN.
// Revision : 1.0
// ==========================================================================
module noc_rr_arbiter_node #(
    parameter int BIT_WIDTH     = 512,
    parameter int ADDR_WIDTH    = 32,
    parameter int RADIX         = 2,
    parameter int NETWORK_DEPTH = 1,
    localparam int SEL_W        = $clog2(RADIX),
    localparam int TAG_W        = SEL_W * NETWORK_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 rst_l,
    input  logic [RADIX-1:0]                     req_valid_IN,
    output logic [RADIX-1:0]                     req_ready_OUT,
    input  logic [RADIX-1:0][BIT_WIDTH-1:0]      req_data_IN,
    input  logic [RADIX-1:0][ADDR_WIDTH-1:0]     req_addr_IN,
    input  logic [RADIX-1:0][TAG_W-1:0]          req_tag_IN,
    output logic                                 req_valid_OUT,
    input  logic                                 req_ready_IN,
    output logic [BIT_WIDTH-1:0]                 req_data_OUT,
    output logic [ADDR_WIDTH-1:0]                req_addr_OUT,
    output logic [TAG_W-1:0]                     req_tag_OUT,
    input  logic                                 rsp_valid_IN,
    output logic                                 rsp_ready_OUT,
    input  logic [BIT_WIDTH-1:0]                 rsp_data_IN,
    input  logic [TAG_W-1:0]                     rsp_tag_IN,
    output logic [RADIX-1:0]                     rsp_valid_OUT,
    input  logic [RADIX-1:0]                     rsp_ready_IN,
    output logic [BIT_WIDTH-1:0]                 rsp_data_OUT,
    output logic [TAG_W-1:0]                     rsp_tag_OUT
`ifdef NOC_ARB_STATS_EN
    ,
    output logic [RADIX-1:0][15:0]               grant_count_OUT,
    output logic [15:0]                          stall_count_OUT
`endif
);

    localparam int              LOW_W   = (TAG_W > SEL_W) ? (TAG_W - SEL_W) : 1;
    localparam logic [SEL_W:0]  c_radix = (SEL_W + 1)'(RADIX);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t                           r_state;
    state_t                           w_state_nxt;
    logic [RADIX-1:0]                 r_full;
    logic [RADIX-1:0][BIT_WIDTH-1:0]  r_data;
    logic [RADIX-1:0][ADDR_WIDTH-1:0] r_addr;
    logic [RADIX-1:0][LOW_W-1:0]      r_tag;
    logic [SEL_W-1:0]                 r_ptr;
    logic [SEL_W-1:0]                 r_lock_grant;
    logic [SEL_W-1:0]                 w_arb_grant;
    logic [SEL_W-1:0]                 w_grant;
    logic [SEL_W-1:0]                 w_ptr_nxt;
    logic [SEL_W-1:0]                 w_off;
    logic [SEL_W:0]                   w_sum;
    logic [SEL_W:0]                   w_inc;
    logic [RADIX-1:0]                 w_rot;
    logic [RADIX-1:0]                 w_cap;
    logic                             w_any_full;
    logic                             w_req_hs;
    logic                             w_unused_tag;

    // Rotate so bit 0 is the pointer position; the lowest set bit wins.
    always_comb begin
        w_rot = RADIX'({r_full, r_full} >> r_ptr);
        w_off = '0;
        for (int k = RADIX - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = SEL_W'(k);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= c_radix) begin
            w_sum = w_sum - c_radix;
        end
        w_arb_grant = w_sum[SEL_W-1:0];
    end

    assign w_any_full    = |r_full;
    assign w_grant       = (r_state == ST_LOCK) ? r_lock_grant : w_arb_grant;
    assign req_valid_OUT = (r_state == ST_LOCK) || w_any_full;
    assign w_req_hs      = req_valid_OUT && req_ready_IN;
    assign req_ready_OUT = ~r_full;
    assign w_cap         = req_valid_IN & ~r_full;
    assign req_data_OUT  = req_valid_OUT ? r_data[w_grant] : '0;
    assign req_addr_OUT  = req_valid_OUT ? r_addr[w_grant] : '0;
    assign w_unused_tag  = ^{req_tag_IN, r_tag};

    always_comb begin
        w_inc = {1'b0, w_grant} + (SEL_W + 1)'(1);
        w_ptr_nxt = (w_inc >= c_radix) ? '0 : w_inc[SEL_W-1:0];
    end

    generate
        if (TAG_W > SEL_W) begin : g_tag_fwd
            assign req_tag_OUT = req_valid_OUT ? {r_tag[w_grant], w_grant} : '0;
        end else begin : g_tag_leaf
            assign req_tag_OUT = req_valid_OUT ? w_grant : '0;
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ARB:  if (w_any_full && !req_ready_IN) w_state_nxt = ST_LOCK;
            ST_LOCK: if (req_ready_IN) w_state_nxt = ST_ARB;
            default: w_state_nxt = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state      <= ST_ARB;
            r_ptr        <= '0;
            r_lock_grant <= '0;
            r_full       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_ARB && w_any_full && !req_ready_IN) begin
                r_lock_grant <= w_arb_grant;
            end
            if (w_req_hs) begin
                r_ptr <= w_ptr_nxt;
            end
            for (int i = 0; i < RADIX; i++) begin
                if (w_cap[i]) begin
                    r_full[i] <= 1'b1;
                end else if (w_req_hs && w_grant == SEL_W'(i)) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    // Payload is qualified by r_full and gated at the outputs, so no reset needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RADIX; i++) begin
            if (w_cap[i]) begin
                r_data[i] <= req_data_IN[i];
                r_addr[i] <= req_addr_IN[i];
                r_tag[i]  <= req_tag_IN[i][LOW_W-1:0];
            end
        end
    end

    logic                 r_rsp_valid;
    logic [SEL_W-1:0]     r_rsp_sel;
    logic [BIT_WIDTH-1:0] r_rsp_data;
    logic [TAG_W-1:0]     r_rsp_tag;
    logic                 w_rsp_in_range;
    logic                 w_rsp_take;
    logic                 w_rsp_cap;

    generate
        if ((1 << SEL_W) == RADIX) begin : g_sel_full
            assign w_rsp_in_range = 1'b1;
        end else begin : g_sel_part
            assign w_rsp_in_range = ({1'b0, rsp_tag_IN[SEL_W-1:0]} < c_radix);
        end
    endgenerate

    assign w_rsp_take    = r_rsp_valid && rsp_ready_IN[r_rsp_sel];
    assign rsp_ready_OUT = !r_rsp_valid || w_rsp_take;
    assign w_rsp_cap     = rsp_valid_IN && rsp_ready_OUT;
    assign rsp_data_OUT  = r_rsp_data;
    assign rsp_tag_OUT   = r_rsp_tag;

    always_comb begin
        rsp_valid_OUT = '0;
        for (int i = 0; i < RADIX; i++) begin
            rsp_valid_OUT[i] = r_rsp_valid && (r_rsp_sel == SEL_W'(i));
        end
    end

    // An out-of-range index is captured as empty, which drops the reply.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_rsp_valid <= 1'b0;
            r_rsp_sel   <= '0;
            r_rsp_data  <= '0;
            r_rsp_tag   <= '0;
        end else if (w_rsp_cap) begin
            r_rsp_valid <= w_rsp_in_range;
            r_rsp_sel   <= rsp_tag_IN[SEL_W-1:0];
            r_rsp_data  <= rsp_data_IN;
            r_rsp_tag   <= rsp_tag_IN >> SEL_W;
        end else if (w_rsp_take) begin
            r_rsp_valid <= 1'b0;
        end
    end

`ifdef NOC_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            grant_count_OUT <= '0;
            stall_count_OUT <= '0;
        end else begin
            for (int i = 0; i < RADIX; i++) begin
                if (w_req_hs && w_grant == SEL_W'(i) && grant_count_OUT[i] != 16'hFFFF) begin
                    grant_count_OUT[i] <= grant_count_OUT[i] + 16'd1;
                end
            end
            if (r_state == ST_LOCK && stall_count_OUT != 16'hFFFF) begin
                stall_count_OUT <= stall_count_OUT + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/noc_rr_arbiter_node.md
Name: noc_rr_arbiter_node

Overview:
- One radix-R switching node of the core-to-memory tree.
- Request path: a one-entry holding buffer per core-side input, fair round-robin selection, and a single memory-side output.
- The node prepends the winning input index to a route tag.
- Response path: the low tag bits demultiplex memory replies back to the correct core-side port, and the tag is shifted for the next level down.

Parameters:
- BIT_WIDTH, 512, data payload width.
- ADDR_WIDTH, 32, address width.
- RADIX, 2, core-side inputs per node; must be at least 2.
- NETWORK_DEPTH, 1, number of tree levels.
- Derived: SEL_W = $clog2(RADIX).
- Derived: TAG_W = SEL_W*NETWORK_DEPTH.

Ports:
- clk  in  1  clock.
- rst_l  in  1  reset, asynchronous, active-low.
- req_valid_IN  in  [RADIX-1:0]  per-input request valid.
- req_ready_OUT  out  [RADIX-1:0]  per-input buffer empty; a handshake occurs when valid&&ready.
- req_data_IN  in  [RADIX-1:0][BIT_WIDTH-1:0]  write data.
- req_addr_IN  in  [RADIX-1:0][ADDR_WIDTH-1:0]  address.
- req_tag_IN  in  [RADIX-1:0][TAG_W-1:0]  tag built by lower levels.
- req_valid_OUT  out  1  memory-side request valid.
- req_ready_IN  in  1  memory-side accepts.
- req_data_OUT  out  BIT_WIDTH  data of the granted request.
- req_addr_OUT  out  ADDR_WIDTH  address of the granted request.
- req_tag_OUT  out  TAG_W  {granted req_tag[TAG_W-SEL_W-1:0], grant index}.
- rsp_valid_IN  in  1  reply valid.
- rsp_ready_OUT  out  1  reply accepted.
- rsp_data_IN  in  BIT_WIDTH  reply data.
- rsp_tag_IN  in  TAG_W  reply route tag.
- rsp_valid_OUT  out  [RADIX-1:0]  per-port reply valid.
- rsp_ready_IN  in  [RADIX-1:0]  per-port reply ready.
- rsp_data_OUT  out  BIT_WIDTH  reply data, shared by all ports.
- rsp_tag_OUT  out  TAG_W  rsp_tag_IN>>SEL_W, zero-filled from the top.

Behaviour:
- Reset (asynchronous, rst_l low):
  - All holding buffers and the response register are empty.
  - Round-robin pointer = 0; FSM = ARB.
  - Outputs after reset: req_ready_OUT = all 1s; req_valid_OUT = 0; rsp_valid_OUT = 0; rsp_ready_OUT = 1.
  - Data, address and tag outputs = 0.
- Reset mid-operation: all buffered requests and any pending reply are discarded; nothing is replayed.
- Input buffers:
  - On an input handshake, data, address and tag are captured at the clock edge.
  - The buffer's full flag sets on capture and clears on a memory-side handshake for that input.
  - A full buffer deasserts req_ready_OUT[i]. No same-cycle refill: ready reflects the registered empty flag.
- Request latency: an input handshake in cycle N allows req_valid_OUT at the earliest in cycle N+1. Request outputs are driven combinationally from the buffers through the grant mux.
- FSM state ARB:
  - If any buffer is full, grant goes to the first full index at or after the pointer, wrapping modulo RADIX.
  - req_valid_OUT = 1.
  - If req_ready_IN = 1: handshake; clear that buffer; pointer = grant+1 (mod RADIX); stay in ARB.
  - If req_ready_IN = 0: latch the grant and go to LOCK.
- FSM state LOCK:
  - The latched grant is held; outputs stay stable; no re-arbitration, even if a higher-priority input becomes full.
  - On req_ready_IN = 1: handshake; clear the buffer; advance the pointer; go to ARB.
- Fairness: an input that is full is granted within RADIX memory-side handshakes.
- Response path (one-entry register):
  - rsp_ready_OUT = register empty, OR the held reply is being taken this cycle by its selected port.
  - A reply is captured at the clock edge on rsp_valid_IN&&rsp_ready_OUT.
  - In the following cycle, rsp_valid_OUT[tag[SEL_W-1:0]] = 1; all other port valids are 0.
  - The register empties on rsp_ready_IN of the selected port.
  - Simultaneous drain and capture in the same cycle: the new reply replaces the old one, so a new reply is valid every cycle with no bubbles.
- Tag index out of range (RADIX not a power of 2): the reply is dropped. Then rsp_ready_OUT = 1 and no rsp_valid_OUT is asserted.
- Request and response paths are independent; there is no ordering between them.

Optional Feature:
- Macro NOC_ARB_STATS_EN.
- Defined: adds output grant_count_OUT [RADIX-1:0][15:0] and output stall_count_OUT [15:0].
  - grant_count_OUT counts memory-side handshakes per input.
  - stall_count_OUT counts cycles spent in LOCK.
  - Both are saturating at 16'hFFFF and cleared by reset.
- Undefined: these ports and counters are absent. Functional behaviour is identical.

Test Plan:
1. Reset then idle: RADIX=2, hold rst_l low then release, no requests -> req_ready_OUT=2'b11, req_valid_OUT=0, rsp_ready_OUT=1, FSM in ARB.
2. Both inputs request continuously with req_ready_IN=1: inputs 0/1 send addr 0x10/0x20, each with tag 0 -> output alternates 0x10 then 0x20; req_tag_OUT alternates 0,1; a new grant every cycle once the buffers refill.
3. Backpressure lock: input 0 full, req_ready_IN=0 for 3 cycles, input 1 becomes full in the second cycle -> output holds input 0's data and tag for all 3 cycles. On release, input 1 is granted next. With NOC_ARB_STATS_EN, stall_count_OUT=3.
4. Response routing: RADIX=4, NETWORK_DEPTH=2, rsp_tag_IN=4'b1110 -> next cycle rsp_valid_OUT=4'b0100, rsp_tag_OUT=4'b0011.
5. Response streaming: replies every cycle with rsp_ready_IN all 1s -> rsp_ready_OUT stays 1 and one reply is delivered per cycle. Dropping the target port's ready for 1 cycle -> rsp_ready_OUT=0 for exactly that cycle and the held reply is unchanged.
6. Reset mid-transfer: assert rst_l low while in LOCK with both buffers full -> outputs go immediately (asynchronously) to reset values. After release, no stale request reappears and the pointer is 0.
